// File: rtl/avalon_bus_arbiter_pkg.sv
// avalon_bus_arbiter_pkg: shared types and constants for the two-host Avalon-MM arbiter.
// Define ROUND_ROBIN_EN to alternate grants on ties instead of fixed priority.
package avalon_bus_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA} arb_state_t;
  typedef bit host_id_t;
  localparam host_id_t HOST_DATA = 1'b0;
  localparam host_id_t HOST_FETCH = 1'b1;
`ifdef ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif
endpackage

// File: rtl/AvalonMmRw.sv
// AvalonMmRw: Avalon-MM read/write signal bundle with host and agent views.
interface AvalonMmRw #(parameter int AW = 32, parameter int DW = 32);
  logic [AW-1:0] address;
  logic [DW/8-1:0] byteenable;
  logic read;
  logic write;
  logic [DW-1:0] host_to_agent;
  logic [DW-1:0] agent_to_host;
  logic waitrequest;
  logic readdatavalid;
  modport Host (output address, byteenable, read, write, host_to_agent,
                input agent_to_host, waitrequest, readdatavalid);
  modport Agent (input address, byteenable, read, write, host_to_agent,
                 output agent_to_host, waitrequest, readdatavalid);
endinterface

// File: rtl/arb_pick.sv
// arb_pick: two-way grant picker; ties go to prio, or away from last_grant under ROUND_ROBIN_EN.
module arb_pick
  import avalon_bus_arbiter_pkg::*;
(
  input logic [1:0] req,
  input host_id_t last_grant,
  input host_id_t prio,
  output host_id_t grant
);
  always_comb grant = (req == 2'b11) ? (RR_EN ? ~last_grant : prio) : req[1];
endmodule

// File: rtl/avalon_bus_arbiter.sv
// avalon_bus_arbiter: shares one Avalon-MM agent between data (host0) and fetch (host1), one transaction at a time.
// Tie-break is fixed priority unless ROUND_ROBIN_EN is defined.
module avalon_bus_arbiter
  import avalon_bus_arbiter_pkg::*;
#(
  parameter host_id_t PRIORITY_HOST = HOST_DATA
) (
  input logic clk,
  input logic rst,
  AvalonMmRw.Agent host0,
  AvalonMmRw.Agent host1,
  AvalonMmRw.Host bus,
  output logic grant_dbg,
  output logic busy
);
  arb_state_t state, state_next;
  host_id_t grant, last_grant, pick;
  logic [1:0] req;
  logic g_read, g_write, issue, active;
  assign req = {host1.read | host1.write, host0.read | host0.write};
  arb_pick u_pick (.req(req), .last_grant(last_grant), .prio(PRIORITY_HOST), .grant(pick));
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      grant <= HOST_DATA;
      last_grant <= HOST_FETCH;
    end else begin
      state <= state_next;
      if (state == IDLE && |req) begin
        grant <= pick;
        last_grant <= pick;
      end
    end
  end
  assign g_read = grant ? host1.read : host0.read;
  assign g_write = grant ? host1.write : host0.write;
  assign issue = state == ISSUE;
  assign active = state != IDLE;
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: state_next = |req ? ISSUE : IDLE;
      ISSUE: state_next = !(g_read || g_write) ? IDLE :
                          bus.waitrequest ? ISSUE :
                          (g_read && !bus.readdatavalid) ? WAIT_DATA : IDLE;
      WAIT_DATA: state_next = bus.readdatavalid ? IDLE : WAIT_DATA;
      default: state_next = IDLE;
    endcase
  end
  assign bus.read = issue & g_read;
  assign bus.write = issue & g_write & ~g_read;
  assign bus.address = grant ? host1.address : host0.address;
  assign bus.byteenable = grant ? host1.byteenable : host0.byteenable;
  assign bus.host_to_agent = grant ? host1.host_to_agent : host0.host_to_agent;
  // Only the granted host in ISSUE sees the downstream stall; everyone else is held off.
  assign host0.waitrequest = !(issue && grant == HOST_DATA) || bus.waitrequest;
  assign host1.waitrequest = !(issue && grant == HOST_FETCH) || bus.waitrequest;
  assign host0.readdatavalid = bus.readdatavalid && active && grant == HOST_DATA;
  assign host1.readdatavalid = bus.readdatavalid && active && grant == HOST_FETCH;
  assign host0.agent_to_host = bus.agent_to_host;
  assign host1.agent_to_host = bus.agent_to_host;
  assign grant_dbg = grant;
  assign busy = active;
endmodule
